// File: rtl/demux2_pkg.sv
// rtl/demux2_pkg.sv - route FSM states and route encodings for the 1:2 stream demultiplexer
package demux2_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOCK0 = 2'd1,
    LOCK1 = 2'd2
  } route_state_e;

  localparam logic ROUTE_OUT1 = 1'b0;
  localparam logic ROUTE_OUT2 = 1'b1;

  function automatic route_state_e lock_state(input logic route);
    return (route == ROUTE_OUT2) ? LOCK1 : LOCK0;
  endfunction

endpackage

// File: rtl/demux2_stream_slot.sv
// rtl/demux2_stream_slot.sv - one-entry registered output slot with load/drain and free flag
module stream_slot #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  input  logic             load_last,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic             out_last,
  output logic             free
);

  logic             valid_q, valid_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             last_q, last_d;

  // A draining slot counts as free so it can be refilled without a bubble.
  assign free = ~valid_q | out_ready;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    last_d  = last_q;
    if (load) begin
      valid_d = 1'b1;
      data_d  = load_data;
      last_d  = load_last;
    end else if (valid_q && out_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      last_q  <= 1'b0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      last_q  <= last_d;
    end
  end

  assign out_valid = valid_q;
  assign out_data  = data_q;
  assign out_last  = last_q;

endmodule

// File: rtl/demux2_stream.sv
// rtl/demux2_stream.sv - registered 1:2 stream demultiplexer with optional per-packet route lock
module demux2_stream
  import demux2_pkg::*;
#(
  parameter int WIDTH       = 1,
  parameter int PACKET_MODE = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_last,
  input  logic             in_sel,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out1_data,
  output logic             out1_last,
  output logic             out1_valid,
  input  logic             out1_ready,
  output logic [WIDTH-1:0] out2_data,
  output logic             out2_last,
  output logic             out2_valid,
  input  logic             out2_ready
);

  route_state_e state_q, state_d;
  logic         route;
  logic         free1, free2;
  logic         accept;
  logic         load1, load2;

  // While locked the packet's first-beat route wins over in_sel.
  always_comb begin
    route = in_sel;
    if (PACKET_MODE != 0) begin
      case (state_q)
        LOCK0:   route = ROUTE_OUT1;
        LOCK1:   route = ROUTE_OUT2;
        default: route = in_sel;
      endcase
    end
  end

  assign in_ready = ~rst & ((route == ROUTE_OUT2) ? free2 : free1);
  assign accept   = in_valid & in_ready;
  assign load1    = accept & (route == ROUTE_OUT1);
  assign load2    = accept & (route == ROUTE_OUT2);

  always_comb begin
    state_d = state_q;
    if (PACKET_MODE != 0 && accept) begin
      if (in_last) begin
        state_d = IDLE;
      end else if (state_q == IDLE) begin
        state_d = lock_state(route);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  stream_slot #(.WIDTH(WIDTH)) u_slot1 (
    .clk       (clk),
    .rst       (rst),
    .load      (load1),
    .load_data (in_data),
    .load_last (in_last),
    .out_ready (out1_ready),
    .out_valid (out1_valid),
    .out_data  (out1_data),
    .out_last  (out1_last),
    .free      (free1)
  );

  stream_slot #(.WIDTH(WIDTH)) u_slot2 (
    .clk       (clk),
    .rst       (rst),
    .load      (load2),
    .load_data (in_data),
    .load_last (in_last),
    .out_ready (out2_ready),
    .out_valid (out2_valid),
    .out_data  (out2_data),
    .out_last  (out2_last),
    .free      (free2)
  );

endmodule

// File: tb/tb_demux2_stream.sv
// tb/tb_demux2_stream.sv - scoreboard bench for demux2_stream, packet-mode and beat-mode instances
module tb_demux2_stream;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [1:0][7:0] in_data;
  logic [1:0]      in_last, in_sel, in_valid;
  wire  [1:0]      in_ready;
  wire  [1:0][7:0] o1_data, o2_data;
  wire  [1:0]      o1_last, o1_valid, o2_last, o2_valid;
  logic [1:0]      o1_ready, o2_ready;

  // Instance 0 locks routes per packet, instance 1 routes every beat by in_sel.
  demux2_stream #(.WIDTH(8), .PACKET_MODE(1)) dut_pkt (
    .clk(clk), .rst(rst),
    .in_data(in_data[0]), .in_last(in_last[0]), .in_sel(in_sel[0]),
    .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .out1_data(o1_data[0]), .out1_last(o1_last[0]), .out1_valid(o1_valid[0]), .out1_ready(o1_ready[0]),
    .out2_data(o2_data[0]), .out2_last(o2_last[0]), .out2_valid(o2_valid[0]), .out2_ready(o2_ready[0])
  );

  demux2_stream #(.WIDTH(8), .PACKET_MODE(0)) dut_beat (
    .clk(clk), .rst(rst),
    .in_data(in_data[1]), .in_last(in_last[1]), .in_sel(in_sel[1]),
    .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .out1_data(o1_data[1]), .out1_last(o1_last[1]), .out1_valid(o1_valid[1]), .out1_ready(o1_ready[1]),
    .out2_data(o2_data[1]), .out2_last(o2_last[1]), .out2_valid(o2_valid[1]), .out2_ready(o2_ready[1])
  );

  int checks = 0;
  int failures = 0;

  // Expected beats {last,data}, indexed inst*2 + route.
  logic [8:0] exp_q [4][$];
  bit   [1:0] pm = 2'b01;
  bit   [1:0] in_pkt = 2'b00;
  bit   [1:0] lock_r = 2'b00;

  logic       rdy_mode = 1'b0;
  logic [1:0] f1 = 2'b11, f2 = 2'b11;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic clear_model();
    for (int q = 0; q < 4; q++) exp_q[q].delete();
    in_pkt = 2'b00;
  endtask

  initial begin
    o1_ready = 2'b00;
    o2_ready = 2'b00;
    forever begin
      @(negedge clk);
      #1;
      if (rdy_mode) begin
        o1_ready = 2'($urandom_range(0, 3));
        o2_ready = 2'($urandom_range(0, 3));
      end else begin
        o1_ready = f1;
        o2_ready = f2;
      end
    end
  end

  // Monitor: every presented beat must match the head of its queue; handshakes pop it.
  initial begin
    forever begin
      @(negedge clk);
      #4;
      if (!rst) begin
        for (int i = 0; i < 2; i++) begin
          for (int k = 0; k < 2; k++) begin
            logic       v, r, l;
            logic [7:0] d;
            int         idx;
            v   = (k == 1) ? o2_valid[i] : o1_valid[i];
            r   = (k == 1) ? o2_ready[i] : o1_ready[i];
            l   = (k == 1) ? o2_last[i]  : o1_last[i];
            d   = (k == 1) ? o2_data[i]  : o1_data[i];
            idx = i * 2 + k;
            if (v) begin
              checks++;
              if (exp_q[idx].size() == 0) begin
                failures++;
                $display("FAIL unexpected_beat inst%0d out%0d actual={last=%b,data=%h} required=none", i, k + 1, l, d);
              end else if ({l, d} !== exp_q[idx][0]) begin
                failures++;
                $display("FAIL beat inst%0d out%0d actual={last=%b,data=%h} required={last=%b,data=%h}",
                         i, k + 1, l, d, exp_q[idx][0][8], exp_q[idx][0][7:0]);
              end
              if (r && exp_q[idx].size() > 0) void'(exp_q[idx].pop_front());
            end
          end
        end
      end
    end
  end

  // Presents one beat and holds it until accepted; returns cycles spent waiting.
  task automatic send(input int i, input logic [7:0] d, input logic s, input logic l, output int waits);
    int route;
    waits = 0;
    @(negedge clk);
    in_data[i] = d;
    in_sel[i]  = s;
    in_last[i] = l;
    in_valid[i] = 1'b1;
    forever begin
      #4;
      if (in_ready[i]) begin
        route = (pm[i] && in_pkt[i]) ? int'(lock_r[i]) : int'(s);
        exp_q[i * 2 + route].push_back({l, d});
        if (pm[i]) begin
          in_pkt[i] = ~l;
          lock_r[i] = route[0];
        end
        @(posedge clk);
        #1;
        in_valid[i] = 1'b0;
        break;
      end
      waits++;
      if (waits > 200) begin
        checks++;
        failures++;
        $display("FAIL accept_timeout inst%0d actual=no_accept required=accept_within_200", i);
        in_valid[i] = 1'b0;
        break;
      end
      @(negedge clk);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    int w;
    in_data  = '0;
    in_last  = '0;
    in_sel   = '0;
    in_valid = '0;
    rst = 1'b1;
    #1;
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("rst_in_ready%0d", i), 32'(in_ready[i]), 0);
      chk($sformatf("rst_out1_valid%0d", i), 32'(o1_valid[i]), 0);
      chk($sformatf("rst_out2_valid%0d", i), 32'(o2_valid[i]), 0);
      chk($sformatf("rst_out1_data%0d", i), 32'({o1_last[i], o1_data[i]}), 0);
      chk($sformatf("rst_out2_data%0d", i), 32'({o2_last[i], o2_data[i]}), 0);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Single beat to out1, one-cycle latency; next beat sel=1 proves FSM stayed IDLE.
    send(0, 8'hA5, 1'b0, 1'b1, w);
    chk("single_latency_out1_valid", 32'(o1_valid[0]), 1);
    chk("single_latency_out1_data", 32'(o1_data[0]), 32'h A5);
    chk("single_out2_quiet", 32'(o2_valid[0]), 0);
    send(0, 8'hA6, 1'b1, 1'b1, w);

    // Four-beat packet with toggling sel, both modes.
    for (int i = 0; i < 2; i++) begin
      send(i, 8'h31, 1'b1, 1'b0, w);
      send(i, 8'h32, 1'b0, 1'b0, w);
      send(i, 8'h33, 1'b1, 1'b0, w);
      send(i, 8'h34, 1'b0, 1'b1, w);
      send(i, 8'h35, 1'b0, 1'b1, w);
    end

    // Stalled out2 holds its beat and blocks only beats routed there.
    repeat (3) @(negedge clk);
    f2 = 2'b00;
    send(0, 8'h11, 1'b1, 1'b1, w);
    @(negedge clk);
    in_data[0] = 8'h22;
    in_sel[0]  = 1'b1;
    in_last[0] = 1'b1;
    in_valid[0] = 1'b1;
    for (int c = 0; c < 3; c++) begin
      #4;
      chk("stall_in_ready", 32'(in_ready[0]), 0);
      chk("stall_out2_data_held", 32'(o2_data[0]), 32'h11);
      @(negedge clk);
    end
    in_valid[0] = 1'b0;
    send(0, 8'h61, 1'b0, 1'b0, w);
    chk("bypass_beat0_waits", 32'(w), 0);
    send(0, 8'h62, 1'b1, 1'b0, w);
    chk("bypass_beat1_waits", 32'(w), 0);
    send(0, 8'h63, 1'b1, 1'b1, w);
    chk("bypass_beat2_waits", 32'(w), 0);
    f2 = 2'b11;
    send(0, 8'h22, 1'b1, 1'b1, w);
    chk("drain_refill_waits", 32'(w), 0);
    chk("drain_refill_valid", 32'(o2_valid[0]), 1);
    chk("drain_refill_data", 32'(o2_data[0]), 32'h22);

    // Sixteen back-to-back beats to out1.
    for (int b = 0; b < 16; b++) begin
      send(1, 8'(8'h40 + b), 1'b0, (b == 15), w);
      chk($sformatf("burst_waits_beat%0d", b), 32'(w), 0);
    end

    // Reset while locked to out2 with out2 full.
    repeat (2) @(negedge clk);
    f2 = 2'b00;
    send(0, 8'h50, 1'b1, 1'b0, w);
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_out2_valid", 32'(o2_valid[0]), 0);
    chk("async_rst_in_ready0", 32'(in_ready[0]), 0);
    chk("async_rst_in_ready1", 32'(in_ready[1]), 0);
    clear_model();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    f2 = 2'b11;
    send(0, 8'h52, 1'b0, 1'b1, w);
    chk("post_rst_out1_valid", 32'(o1_valid[0]), 1);
    chk("post_rst_out1_data", 32'(o1_data[0]), 32'h52);
    chk("post_rst_out2_quiet", 32'(o2_valid[0]), 0);

    // Randomized traffic with random back-pressure.
    rdy_mode = 1'b1;
    for (int n = 0; n < 400; n++) begin
      int i;
      i = int'($urandom_range(0, 1));
      send(i, 8'($urandom), 1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0), w);
      if ($urandom_range(0, 4) == 0) @(negedge clk);
    end
    rdy_mode = 1'b0;
    f1 = 2'b11;
    f2 = 2'b11;
    repeat (6) @(negedge clk);
    for (int q = 0; q < 4; q++) chk($sformatf("drained_queue%0d", q), 32'(exp_q[q].size()), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
